matriz_leds_scan_param: RTL
===========================

// Module: matriz_leds_scan_param
// PURPOSE
//  Parametrised puzzle LED-matrix controller, successor of the fixed 8x8 block. Holds a
//  ROWS x COLS virtual LED state; each button press toggles a parameter-defined cell region.
//  Drives a row-multiplexed matrix with a prescaled scan and anti-ghosting blanking.
//  Reports level completion and a move count to the game control unit.
// PARAMETERS
//  ROWS       8     matrix rows (>=2)
//  COLS       8     matrix columns (>=1)
//  N_BTN      8     number of puzzle buttons
//  BTN_MASK   {N_BTN*ROWS*COLS{1'b0}}  toggle regions; cell (r,c) of button b = bit b*ROWS*COLS + r*COLS + c
//  SCAN_DIV   1000  clk cycles per row period (> BLANK_CYC)
//  BLANK_CYC  16    cycles at start of each row period with matrix dark (0 allowed)
//  LVL_W      3     width of nivel
// PORTS
//  clk              in   1          system clock
//  rst              in   1          asynchronous reset, active-high
//  botoes           in   N_BTN      raw buttons, active-high, asynchronous to clk
//  limpar           in   1          synchronous clear of LED state and move counter
//  nivel            in   LVL_W      current level
//  nivel_concluido  out  1          level target met (registered)
//  jogadas          out  8          move counter, saturating
//  colunas          out  COLS       column drive, active-high, for the active row
//  linhas           out  ROWS       row select, active-low, one-hot-zero
// BEHAVIOUR
//  Reset (async, rst=1): all LED state 0; sync/edge regs 0; jogadas=0; nivel_concluido=0;
//   linha_atual=0; scan counter=0 -> linhas=all 1, colunas=0.
//  Input path: botoes passes through 2-FF synchroniser then prev-register. Rise = sync & ~prev.
//   Each press yields exactly one 1-cycle pulse; held buttons do nothing further.
//   Latency: a botoes edge is visible in LED state 3 cycles after it is sampled.
//  Toggle: on a cycle with rise != 0, state <= state ^ (OR-free XOR of BTN_MASK of every rising
//   button). Two buttons rising the same cycle whose regions overlap leave overlap cells unchanged.
//  Move count: jogadas +1 on any cycle with rise != 0 (simultaneous rises count once);
//   saturates at 255, no wrap.
//  limpar=1: state<=0, jogadas<=0 next edge; overrides toggles the same cycle. Scan is unaffected.
//  Level check: target rows T = min(2*nivel+1, ROWS). nivel_concluido <= 1 iff rows 0..T-1 all
//   ones, evaluated on the current (pre-update) state -> 1-cycle lag after the state register.
//   nivel >= (ROWS+1)/2 + 1 -> nivel_concluido <= 0. Changing nivel does not touch LED state.
//  Scan: counter 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and linha_atual increments,
//   ROWS-1 wraps to 0. Counter < BLANK_CYC: linhas=all 1, colunas=0. Otherwise
//   linhas=~(1<<linha_atual), colunas=state[linha_atual]. At most one row low at any time.
//  colunas shows state live: a toggle during an active row period appears next cycle.
//  Reset mid-scan or mid-press: everything returns to reset values immediately; a button held
//   through reset release produces a rise (prev=0) 2 cycles after rst falls.
// TESTING
//  T1 reset: assert rst mid-scan -> linhas=8'hFF, colunas=0, jogadas=0, nivel_concluido=0 at once.
//  T2 press: BTN_MASK b0 = rows0-2 cols0-2; pulse botoes[0] 5 cycles -> rows0-2 = 8'h07, jogadas=1;
//   hold 100 cycles -> no further change.
//  T3 overlap: b2,b3 share cell(5,3); press both same cycle -> (5,3)=0, others set, jogadas+=1.
//  T4 level: nivel=1, preload rows0-2=8'hFF via presses -> nivel_concluido=1 one cycle after state;
//   nivel=2 -> 0; nivel=7 -> 0.
//  T5 scan: SCAN_DIV=10, BLANK_CYC=2 -> per row 2 cycles linhas=FF, 8 cycles linhas=~(1<<r);
//   row 7 followed by row 0; colunas=0 during blank.
//  T6 saturate/clear: 300 presses -> jogadas=255; limpar with simultaneous press -> state 0, jogadas 0.

Source files
------------

// File: rtl/matriz_leds_scan_param.sv
// matriz_leds_scan_param: parametrised puzzle LED-matrix with region toggles, level check and blanked row scan
module matriz_leds_scan_param #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int N_BTN = 8,
    parameter logic [N_BTN*ROWS*COLS-1:0] BTN_MASK = '0,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_CYC = 16,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] botoes,
    input  logic             limpar,
    input  logic [LVL_W-1:0] nivel,
    output logic             nivel_concluido,
    output logic [7:0]       jogadas,
    output logic [COLS-1:0]  colunas,
    output logic [ROWS-1:0]  linhas
);
    localparam int CELLS = ROWS * COLS;
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int RW = $clog2(ROWS);

    logic [N_BTN-1:0] s1, s2, prev, rise;
    logic [CELLS-1:0] state, flip, target;
    logic [CW-1:0] cnt;
    logic [RW-1:0] linha_atual;
    logic meets, blank;

    // two-flop synchroniser plus previous-value register for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            prev <= '0;
        end else begin
            s1 <= botoes;
            s2 <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;

    // combined toggle pattern: overlapping regions of simultaneous presses cancel
    always_comb begin
        flip = '0;
        for (int b = 0; b < N_BTN; b++)
            if (rise[b]) flip = flip ^ BTN_MASK[b*CELLS +: CELLS];
    end

    // level target: the first min(2*nivel+1, ROWS) rows must be fully lit
    always_comb begin
        int t;
        t = 2 * int'(nivel) + 1;
        if (t > ROWS) t = ROWS;
        target = '0;
        for (int i = 0; i < CELLS; i++)
            if (i < t * COLS) target[i] = 1'b1;
        meets = (int'(nivel) <= (ROWS + 1) / 2) && ((state & target) == target);
    end

    // LED state, saturating move counter and registered completion flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
            jogadas <= '0;
            nivel_concluido <= 1'b0;
        end else begin
            nivel_concluido <= meets;
            if (limpar) begin
                state <= '0;
                jogadas <= '0;
            end else if (|rise) begin
                state <= state ^ flip;
                jogadas <= jogadas == 8'd255 ? jogadas : jogadas + 8'd1;
            end
        end
    end

    // row-period prescaler and active-row pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            linha_atual <= '0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            linha_atual <= linha_atual == RW'(ROWS - 1) ? '0 : linha_atual + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // matrix drive: dark during the blanking window, else the live state of the active row
    always_comb begin
        blank = int'(cnt) < BLANK_CYC;
        linhas = blank ? '1 : ~(ROWS'(1) << linha_atual);
        colunas = blank ? '0 : state[linha_atual*COLS +: COLS];
    end
endmodule
